// File: rtl/aes_axis_wrapper_if.sv
// AXI4-Stream channel bundle (32-bit data, valid/ready/last) used by aes_axis_wrapper.
interface aes_axis_wrapper_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/aes_axis_wrapper.sv
// AES-128 ECB engine behind 32-bit AXI4-Stream command/data streams, one round per cycle.
// Define AES_BYPASS_EN to decode CMD_BYPASS (blocks echoed unchanged, 1-cycle latency).
module aes_axis_wrapper (
  input  logic               aclk,
  input  logic               areset,
  aes_axis_wrapper_if.slave  s_axis,
  aes_axis_wrapper_if.master m_axis
);

  localparam logic [31:0] CMD_SET_KEY = 32'h0000_0001;
  localparam logic [31:0] CMD_ENCRYPT = 32'h0000_0002;
`ifdef AES_BYPASS_EN
  localparam logic [31:0] CMD_BYPASS  = 32'h0000_0004;
`endif

  // Entry 0 sits in the MSBs so SBOX[x] indexes directly.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [2:0] {
    StIdle, StKey, StDataIn, StProcess, StDataOut, StDrain
  } state_e;

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] data_q, data_d;
  logic [127:0] rk_q, rk_d;
  logic [127:0] key_q, key_d;
  logic         last_q, last_d;
  logic         byp_q, byp_d;
  logic         rdy_q;
  logic         s_fire, m_fire;
  logic [127:0] rk_next;
  logic [31:0]  out_word;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [127:0] expand_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = {SBOX[w3[23:16]], SBOX[w3[15:8]], SBOX[w3[7:0]], SBOX[w3[31:24]]} ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic final_rnd);
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] mc;
    for (int i = 0; i < 16; i++) sb[i] = SBOX[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) sr[r+4*c] = sb[r+4*((c+r)%4)];
    end
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c];
      a1 = sr[4*c+1];
      a2 = sr[4*c+2];
      a3 = sr[4*c+3];
      if (final_rnd) begin
        mc[127-32*c -: 32] = {a0, a1, a2, a3};
      end else begin
        mc[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
      end
    end
    return mc ^ rk;
  endfunction

  // Writes word idx; with pad set, the words after idx are cleared (short final block).
  function automatic logic [127:0] put_word(input logic [127:0] blk, input logic [1:0] idx,
                                            input logic [31:0] w, input logic pad);
    logic [127:0] r;
    r = blk;
    for (int i = 0; i < 4; i++) begin
      if (2'(i) == idx) begin
        r[127-32*i -: 32] = w;
      end else if (pad && (2'(i) > idx)) begin
        r[127-32*i -: 32] = 32'h0;
      end
    end
    return r;
  endfunction

  assign s_axis.tready = rdy_q &&
                         (state_q inside {StIdle, StKey, StDataIn, StDrain});
  assign s_fire        = s_axis.tvalid && s_axis.tready;
  assign m_axis.tvalid = (state_q == StDataOut);
  assign m_fire        = m_axis.tvalid && m_axis.tready;
  assign rk_next       = expand_key(rk_q, rcon(cnt_q));

  always_comb begin
    case (cnt_q[1:0])
      2'd0:    out_word = data_q[127:96];
      2'd1:    out_word = data_q[95:64];
      2'd2:    out_word = data_q[63:32];
      default: out_word = data_q[31:0];
    endcase
  end

  assign m_axis.tdata = m_axis.tvalid ? out_word : 32'h0;
  assign m_axis.tlast = m_axis.tvalid && last_q && (cnt_q[1:0] == 2'd3);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rk_d    = rk_q;
    key_d   = key_q;
    last_d  = last_q;
    byp_d   = byp_q;
    case (state_q)
      StIdle: begin
        if (s_fire) begin
          cnt_d = 4'd0;
          if (s_axis.tlast) begin
            state_d = StIdle;
          end else if (s_axis.tdata == CMD_SET_KEY) begin
            state_d = StKey;
          end else if (s_axis.tdata == CMD_ENCRYPT) begin
            state_d = StDataIn;
            byp_d   = 1'b0;
`ifdef AES_BYPASS_EN
          end else if (s_axis.tdata == CMD_BYPASS) begin
            state_d = StDataIn;
            byp_d   = 1'b1;
`endif
          end else begin
            state_d = StDrain;
          end
        end
      end
      StKey: begin
        if (s_fire) begin
          data_d = put_word(data_q, cnt_q[1:0], s_axis.tdata, 1'b0);
          if (cnt_q == 4'd3) begin
            key_d   = {data_q[127:32], s_axis.tdata};
            state_d = s_axis.tlast ? StIdle : StDrain;
          end else if (s_axis.tlast) begin
            state_d = StIdle;  // short key: key register untouched
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      StDataIn: begin
        if (s_fire) begin
          data_d = put_word(data_q, cnt_q[1:0], s_axis.tdata, s_axis.tlast);
          if ((cnt_q == 4'd3) || s_axis.tlast) begin
            state_d = StProcess;
            cnt_d   = 4'd0;
            last_d  = s_axis.tlast;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      StProcess: begin
        if (cnt_q == 4'd0) begin
          rk_d = key_q;
          if (byp_q) begin
            state_d = StDataOut;
          end else begin
            data_d = data_q ^ key_q;
            cnt_d  = 4'd1;
          end
        end else begin
          data_d = aes_round(data_q, rk_next, cnt_q == 4'd10);
          rk_d   = rk_next;
          if (cnt_q == 4'd10) begin
            state_d = StDataOut;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      StDataOut: begin
        if (m_fire) begin
          if (cnt_q[1:0] == 2'd3) begin
            cnt_d   = 4'd0;
            state_d = last_q ? StIdle : StDataIn;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      StDrain: begin
        if (s_fire && s_axis.tlast) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      data_q  <= 128'h0;
      rk_q    <= 128'h0;
      key_q   <= 128'h0;
      last_q  <= 1'b0;
      byp_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rk_q    <= rk_d;
      key_q   <= key_d;
      last_q  <= last_d;
      byp_q   <= byp_d;
      rdy_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_axis_wrapper.sv
// Directed scoreboard bench for aes_axis_wrapper: FIPS-197 / zero-key vectors, framing,
// backpressure, drained packets and asynchronous reset.
module tb_aes_axis_wrapper;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] ZERO_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic aclk;
  logic areset;
  aes_axis_wrapper_if s_if ();
  aes_axis_wrapper_if m_if ();

  aes_axis_wrapper dut (
    .aclk   (aclk),
    .areset (areset),
    .s_axis (s_if),
    .m_axis (m_if)
  );

  exp_t        sb [$];
  int          tests;
  int          fails;
  int          cyc;
  int          hs_cycle;
  int          bp_phase;
  logic        bp_en;
  logic        gap_en;
  logic        held_v;
  logic [31:0] held_d;
  logic        held_l;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_blk(input logic [127:0] b, input logic last);
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.data = b[127-32*i -: 32];
      e.last = last && (i == 3);
      sb.push_back(e);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    s_if.tdata  = d;
    s_if.tlast  = l;
    s_if.tvalid = 1'b1;
    @(negedge aclk);
    while (!s_if.tready && n < 500) begin
      @(negedge aclk);
      n++;
    end
    if (!s_if.tready) begin
      tests++;
      fails++;
      $error("FAIL send_timeout: got tready=0 expected tready=1 for word %h", d);
      s_if.tvalid = 1'b0;
      return;
    end
    @(posedge aclk);
    #1;
    hs_cycle    = cyc;
    s_if.tvalid = 1'b0;
    if (gap_en) begin
      n = $urandom_range(0, 2);
      repeat (n) begin
        @(posedge aclk);
        #1;
      end
    end
  endtask

  task automatic send_blk(input logic [127:0] b, input logic last);
    for (int i = 0; i < 4; i++) send(b[127-32*i -: 32], last && (i == 3));
  endtask

  task automatic drain(input int extra);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 600) begin
      @(posedge aclk);
      n++;
    end
    #1;
    check("sb_empty", sb.size(), 0);
    repeat (extra) @(posedge aclk);
    #1;
  endtask

  // Output monitor: pops the scoreboard on each handshake, checks stability while stalled.
  always @(negedge aclk) begin
    if (areset) begin
      held_v = 1'b0;
    end else if (m_if.tvalid) begin
      if (m_if.tready) begin
        tests++;
        assert (sb.size() != 0) else begin
          fails++;
          $error("FAIL unexpected_out: got %h expected no output", m_if.tdata);
        end
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("out_data", m_if.tdata, e.data);
          check("out_last", m_if.tlast, e.last);
        end
        check("s_ready_low_out", s_if.tready, 0);
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          check("stall_data", m_if.tdata, held_d);
          check("stall_last", m_if.tlast, held_l);
        end
        held_v = 1'b1;
        held_d = m_if.tdata;
        held_l = m_if.tlast;
      end
    end
  end

  initial begin
    bp_phase    = 0;
    m_if.tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      if (bp_en) begin
        m_if.tready = (bp_phase >= 2);
        bp_phase    = (bp_phase + 1) % 8;
      end else begin
        m_if.tready = 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tests       = 0;
    fails       = 0;
    bp_en       = 1'b0;
    gap_en      = 1'b0;
    held_v      = 1'b0;
    areset      = 1'b1;
    s_if.tdata  = 32'h0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    check("rst_m_tvalid", m_if.tvalid, 0);
    check("rst_m_tdata", m_if.tdata, 0);
    check("rst_m_tlast", m_if.tlast, 0);
    check("rst_s_tready", s_if.tready, 0);
    areset = 1'b0;
    #1;
    check("s_tready_before_edge", s_if.tready, 0);
    @(posedge aclk);
    #1;
    check("s_tready_after_edge", s_if.tready, 1);

    // Zero key, two zero blocks in one packet
    send(32'h2, 1'b0);
    push_blk(ZERO_CT, 1'b0);
    push_blk(ZERO_CT, 1'b1);
    send_blk(128'h0, 1'b0);
    send_blk(128'h0, 1'b1);
    drain(5);

    // Short packet: two data words, zero padded
    push_blk(ZERO_CT, 1'b1);
    send(32'h2, 1'b0);
    send(32'h0, 1'b0);
    send(32'h0, 1'b1);
    drain(5);

    // FIPS-197 vector with latency check
    send(32'h1, 1'b0);
    send_blk(FIPS_KEY, 1'b1);
    push_blk(FIPS_CT, 1'b1);
    send(32'h2, 1'b0);
    send_blk(FIPS_PT, 1'b1);
    n = 0;
    @(negedge aclk);
    while (!m_if.tvalid && n < 40) begin
      @(negedge aclk);
      n++;
    end
    check("latency", 32'(cyc - hs_cycle), 32'd11);
    drain(5);

    // Short key keeps the old key
    send(32'h1, 1'b0);
    send(32'hdeadbeef, 1'b0);
    send(32'hcafef00d, 1'b1);
    push_blk(FIPS_CT, 1'b1);
    send(32'h2, 1'b0);
    send_blk(FIPS_PT, 1'b1);
    drain(5);

    // Unknown command is drained
    send(32'h80, 1'b0);
    send_blk(FIPS_PT, 1'b1);
    drain(30);

    // Bypass command
    send(32'h4, 1'b0);
`ifdef AES_BYPASS_EN
    push_blk(FIPS_PT, 1'b1);
`endif
    send_blk(FIPS_PT, 1'b1);
    drain(30);

    // Multi-block packet
    send(32'h2, 1'b0);
    push_blk(FIPS_CT, 1'b0);
    push_blk(FIPS_CT, 1'b1);
    send_blk(FIPS_PT, 1'b0);
    send_blk(FIPS_PT, 1'b1);
    drain(5);

    // Backpressure and gapped input
    bp_en  = 1'b1;
    gap_en = 1'b1;
    send(32'h2, 1'b0);
    push_blk(FIPS_CT, 1'b0);
    push_blk(FIPS_CT, 1'b1);
    send_blk(FIPS_PT, 1'b0);
    send_blk(FIPS_PT, 1'b1);
    drain(5);
    bp_en  = 1'b0;
    gap_en = 1'b0;
    repeat (2) @(posedge aclk);
    #1;

    // Reset during PROCESS: no output, key cleared
    send(32'h2, 1'b0);
    send_blk(FIPS_PT, 1'b1);
    repeat (3) @(posedge aclk);
    #1;
    areset = 1'b1;
    #1;
    check("midrst_m_tvalid", m_if.tvalid, 0);
    check("midrst_m_tdata", m_if.tdata, 0);
    check("midrst_m_tlast", m_if.tlast, 0);
    check("midrst_s_tready", s_if.tready, 0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    repeat (30) @(posedge aclk);
    #1;
    check("midrst_idle_ready", s_if.tready, 1);
    push_blk(ZERO_CT, 1'b1);
    send(32'h2, 1'b0);
    send_blk(128'h0, 1'b1);
    drain(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
